// File: rtl/row_clear_engine_pkg.sv
// ============================================================================
// Module : row_clear_engine_pkg
// Brief  : Shared definitions: board defaults, FSM encoding, score constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package row_clear_engine_pkg;

  localparam int BLOCKS_WIDE_DEF = 10;
  localparam int BLOCKS_HIGH_DEF = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] SCORE_ONE    = 16'd40;
  localparam logic [15:0] SCORE_TWO    = 16'd100;
  localparam logic [15:0] SCORE_THREE  = 16'd300;
  localparam logic [15:0] SCORE_TETRIS = 16'd1200;
  localparam logic [15:0] SCORE_MAX    = 16'hFFFF;

  // Five or more rows in one operation pay the same as a tetris.
  function automatic logic [15:0] score_increment(input logic [4:0] rows);
    logic [15:0] inc;
    inc = '0;
    case (rows)
      5'd0:    inc = '0;
      5'd1:    inc = SCORE_ONE;
      5'd2:    inc = SCORE_TWO;
      5'd3:    inc = SCORE_THREE;
      default: inc = SCORE_TETRIS;
    endcase
    return inc;
  endfunction

  function automatic logic [15:0] score_sat_add(input logic [15:0] acc,
                                                input logic [15:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return sum[16] ? SCORE_MAX : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/row_clear_engine_row_full_check.sv
// ============================================================================
// Module : row_full_check
// Brief  : Combinational test that every cell of one board row is occupied.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module row_full_check
  import row_clear_engine_pkg::*;
#(
  parameter int BLOCKS_WIDE = BLOCKS_WIDE_DEF
) (
  input  logic [BLOCKS_WIDE-1:0] row,
  output logic                   full
);

  assign full = &row;

endmodule

`default_nettype wire

// File: rtl/row_clear_engine.sv
// ============================================================================
// Module : row_clear_engine
// Brief  : Scans a settled board bottom-up, removing full rows one per cycle.
//          Optional scoring is enabled by defining ROW_CLEAR_SCORE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module row_clear_engine
  import row_clear_engine_pkg::*;
#(
  parameter int BLOCKS_WIDE = BLOCKS_WIDE_DEF,
  parameter int BLOCKS_HIGH = BLOCKS_HIGH_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_in,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_out,
  output logic                               busy,
  output logic                               done,
  output logic [4:0]                         rows_cleared,
  output logic [15:0]                        score
);

  localparam int          c_CELLS    = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam logic [4:0]  c_LAST_ROW = 5'(BLOCKS_HIGH - 1);

  state_t                   r_state;
  logic [4:0]               r_ptr;
  logic [c_CELLS-1:0]       r_board;
  logic                     r_busy;
  logic                     r_done;
  logic [4:0]               r_rows_cleared;

  logic [BLOCKS_WIDE-1:0]   w_row;
  logic                     w_full;
  logic [c_CELLS-1:0]       w_shifted;

  assign w_row = r_board[r_ptr*BLOCKS_WIDE +: BLOCKS_WIDE];

  row_full_check #(
    .BLOCKS_WIDE (BLOCKS_WIDE)
  ) u_row_full_check (
    .row  (w_row),
    .full (w_full)
  );

  // Rows at or above the pointer drop by one; rows below it are untouched.
  for (genvar g = 0; g < BLOCKS_HIGH; g++) begin : g_shift
    if (g == 0) begin : g_top
      assign w_shifted[0 +: BLOCKS_WIDE] = '0;
    end else begin : g_lower
      localparam logic [4:0] c_ROW = 5'(g);
      assign w_shifted[g*BLOCKS_WIDE +: BLOCKS_WIDE] =
        (c_ROW <= r_ptr) ? r_board[(g-1)*BLOCKS_WIDE +: BLOCKS_WIDE]
                         : r_board[g*BLOCKS_WIDE +: BLOCKS_WIDE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_board        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_rows_cleared <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_board        <= board_in;
            r_ptr          <= c_LAST_ROW;
            r_rows_cleared <= '0;
            r_busy         <= 1'b1;
            r_state        <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // A cleared row is re-examined since a new row has dropped into it.
          if (w_full) begin
            r_board        <= w_shifted;
            r_rows_cleared <= r_rows_cleared + 5'd1;
          end else if (r_ptr != 5'd0) begin
            r_ptr <= r_ptr - 5'd1;
          end else begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign board_out    = r_board;
  assign busy         = r_busy;
  assign done         = r_done;
  assign rows_cleared = r_rows_cleared;

`ifdef ROW_CLEAR_SCORE_EN
  logic [15:0] r_score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
    end else if (r_state == ST_DONE) begin
      r_score <= score_sat_add(r_score, score_increment(r_rows_cleared));
    end
  end

  assign score = r_score;
`else
  assign score = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_row_clear_engine.sv
// ============================================================================
// Module : tb_row_clear_engine
// Brief  : Directed self-checking bench for row_clear_engine (10x22 board).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_row_clear_engine;

  localparam int W = 10;
  localparam int H = 22;
  localparam int N = W * H;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] board_in;
  logic [N-1:0] board_out;
  logic         busy;
  logic         done;
  logic [4:0]   rows_cleared;
  logic [15:0]  score;

  int n_cmp;
  int n_fail;

  row_clear_engine #(
    .BLOCKS_WIDE (W),
    .BLOCKS_HIGH (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .board_in     (board_in),
    .board_out    (board_out),
    .busy         (busy),
    .done         (done),
    .rows_cleared (rows_cleared),
    .score        (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] row_val(input int r, input logic [W-1:0] v);
    logic [N-1:0] b;
    b = '0;
    b[r*W +: W] = v;
    return b;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the edge that accepts start; done is sampled #1 after each edge.
  task automatic run_op(input string tag, input logic [N-1:0] b, input int exp_cyc,
                        input int exp_rows, input logic [N-1:0] exp_board);
    int cyc;
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    check({tag, "_busy"}, busy, 1);
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_rows"}, rows_cleared, exp_rows);
    check({tag, "_board"}, board_out, exp_board);
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int n_done;
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    board_in = '0;
    #12;
    check("rst_board", board_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rows", rows_cleared, 0);
    check("rst_score", score, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("empty", '0, 23, 0, '0);
    run_op("one_row", row_val(21, 10'h3FF) | row_val(20, 10'h008), 24, 1, row_val(21, 10'h008));

    board_in = '1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_hold_board", board_out, row_val(21, 10'h008));
    check("idle_hold_rows", rows_cleared, 1);

    run_op("tetris", row_val(18, 10'h3FF) | row_val(19, 10'h3FF) |
                     row_val(20, 10'h3FF) | row_val(21, 10'h3FF), 27, 4, '0);
    run_op("all_full", '1, 45, 22, '0);
    run_op("nonadj", row_val(21, 10'h3FF) | row_val(20, 10'h155) | row_val(19, 10'h3FF),
           25, 2, row_val(21, 10'h155));
    run_op("row0_shift", row_val(5, 10'h3FF) | row_val(4, 10'h3FE) | row_val(0, 10'h001),
           24, 1, row_val(5, 10'h3FE) | row_val(1, 10'h001));

    // Second start during SCAN carries a full board; it must leave no trace.
    @(negedge clk);
    board_in = row_val(21, 10'h3FF) | row_val(20, 10'h008);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    board_in = '1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    board_in = '0;
    n_done   = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check("ignore_done_count", n_done, 1);
    check("ignore_rows", rows_cleared, 1);
    check("ignore_board", board_out, row_val(21, 10'h008));

    // Asynchronous reset in the middle of SCAN.
    @(negedge clk);
    board_in = '1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("mid_scan_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_board", board_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rows", rows_cleared, 0);
    check("mid_rst_score", score, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("after_rst", row_val(21, 10'h3FF) | row_val(20, 10'h008), 24, 1, row_val(21, 10'h008));
`ifdef ROW_CLEAR_SCORE_EN
    check("score_one_row", score, 40);
    rst = 1'b1;
    #1;
    check("score_rst", score, 0);
    @(negedge clk);
    rst = 1'b0;
`else
    check("score_tied", score, 0);
`endif

    run_op("score_tetris", row_val(18, 10'h3FF) | row_val(19, 10'h3FF) |
                           row_val(20, 10'h3FF) | row_val(21, 10'h3FF), 27, 4, '0);
`ifdef ROW_CLEAR_SCORE_EN
    check("score_1200", score, 1200);
    for (int i = 1; i < 55; i++) begin
      run_op("sat_tetris", row_val(18, 10'h3FF) | row_val(19, 10'h3FF) |
                           row_val(20, 10'h3FF) | row_val(21, 10'h3FF), 27, 4, '0);
    end
    check("score_saturated", score, 65535);
`else
    check("score_tied_tetris", score, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/row_clear_engine.md
ROW_CLEAR_ENGINE -- requirements
Module: row_clear_engine

Interface
REQ-001 SHALL have parameter BLOCKS_WIDE, default 10, board columns.
REQ-002 SHALL have parameter BLOCKS_HIGH, default 22, board rows, at most 31.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to process board_in.
REQ-006 SHALL have port board_in  input  BLOCKS_WIDE*BLOCKS_HIGH  settled board after a piece locks.
REQ-007 SHALL have port board_out  output  BLOCKS_WIDE*BLOCKS_HIGH  registered board feeding the display's fallen_pieces input.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse when processing completes.
REQ-010 SHALL have port rows_cleared  output  5  full rows removed by the last operation.
REQ-011 SHALL have port score  output  16  accumulated score; only meaningful when the Configuration feature is enabled.

Function
REQ-012 SHALL use the display's board layout: bit index = col + row*BLOCKS_WIDE, with row 0 at the top.
REQ-013 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-014 SHALL, in IDLE, accept start: board_out <= board_in, row pointer <= BLOCKS_HIGH-1, rows_cleared <= 0, next state SCAN.
REQ-015 SHALL, in SCAN, treat a row as full when all BLOCKS_WIDE bits of the pointed row are 1.
REQ-016 SHALL, on a full row in the same cycle: move rows 0..r-1 down one row, zero row 0, increment rows_cleared, and hold the pointer.
REQ-017 SHALL, on a non-full row: decrement the pointer if r>0, otherwise go to DONE.
REQ-018 SHALL, in DONE: assert done for exactly one cycle, then return to IDLE; busy falls with that return.
REQ-019 SHALL give a latency from the start edge to the done pulse of BLOCKS_HIGH+1+k cycles, where k is the number of full rows.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL accept back-to-back start in the cycle directly after done.
REQ-022 SHALL hold board_out and rows_cleared stable in IDLE.
REQ-023 SHALL always terminate: row 0 is zero after any shift, so an all-full board completes in 2*BLOCKS_HIGH+1 cycles with rows_cleared = BLOCKS_HIGH.

Reset
REQ-024 SHALL, on rst asserted at any time including mid-SCAN, asynchronously force: state IDLE, board_out 0, busy 0, done 0, rows_cleared 0, score 0, pointer 0.
REQ-025 SHALL resume operation on the first clk edge after rst deasserts.

Configuration
REQ-026 SHALL honour macro ROW_CLEAR_SCORE_EN.
REQ-027 SHALL, when ROW_CLEAR_SCORE_EN is defined, update score in the DONE cycle by adding 0/40/100/300/1200 for rows_cleared 0/1/2/3/4, or 1200 for 5 or more.
REQ-028 SHALL saturate the score at 65535 rather than wrap.
REQ-029 SHALL, when ROW_CLEAR_SCORE_EN is undefined, tie score to 0 and include no score logic.

Structure
REQ-030 SHALL take BLOCKS_WIDE/BLOCKS_HIGH defaults from definitions.vh.
REQ-031 SHALL define the FSM state encodings (2 bits) and score constants in definitions.vh.
REQ-032 SHALL contain one sub-module, row_full_check: combinational AND-reduction of a selected row, parameterised by BLOCKS_WIDE.

Verification
REQ-033 SHALL cover: empty board, start -> done at cycle 23, rows_cleared 0, board_out all 0.
REQ-034 SHALL cover: row 21 full, row 20 bit 3 set -> done at cycle 24, rows_cleared 1, board_out has only bit 3+21*10 set.
REQ-035 SHALL cover: rows 18..21 full (tetris), ROW_CLEAR_SCORE_EN defined -> rows_cleared 4, score 1200, board_out all 0, done at cycle 27.
REQ-036 SHALL cover: all 22 rows full -> rows_cleared 22, done at cycle 45, board_out all 0; score saturation checked via 55 tetris operations -> score 65535.
REQ-037 SHALL cover: non-adjacent rows 21 and 19 full, row 20 pattern 0x155 -> rows_cleared 2, pattern relocated to row 21.
REQ-038 SHALL cover: rst asserted mid-SCAN at cycle 5 -> all outputs 0 immediately; start pulsed while busy -> ignored, single done observed.
